// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache: FSM states and width helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_READMISS  = 2'd2
    } state_t;

    localparam int WORD_W   = 32;
    localparam int MAX_WAYS = 8;

    function automatic int log2c(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Age and way-index width; a direct-mapped cache still carries one bit.
    function automatic int age_w(input int ways);
        return (log2c(ways) < 1) ? 1 : log2c(ways);
    endfunction

endpackage

// File: rtl/cache_lru_age.sv
// Per-set true-LRU age counters and victim selection.
module cache_lru_age
    import cache_pkg::*;
#(
    parameter  int WAYS  = 4,
    parameter  int SETS  = 4,
    localparam int IDX_W = log2c(SETS),
    localparam int WAY_W = age_w(WAYS)
) (
    input  logic             clk,
    input  logic             proc_reset_n,
    input  logic [IDX_W-1:0] index,
    input  logic [WAYS-1:0]  valid,
    input  logic [WAY_W-1:0] access_way,
    input  logic             update,
    output logic [WAY_W-1:0] victim
);

    logic [WAY_W-1:0] age [SETS][WAYS];
    logic [WAY_W-1:0] old_age;
    logic             found;

    // A way entering from invalid counts as the oldest, so every other way
    // ages and the set converges to a permutation once full.
    assign old_age = valid[access_way] ? age[index][access_way] : WAY_W'(WAYS - 1);

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= '0;
        end else if (update) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w == int'(access_way))
                    age[index][w] <= '0;
                else if (age[index][w] < old_age)
                    age[index][w] <= age[index][w] + 1'b1;
            end
        end
    end

    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++)
                if (age[index][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back cache with writeback/refill FSM.
// Optional hit/miss/writeback counters under CACHE_PERF_CNT_EN.
module cache_nway
    import cache_pkg::*;
#(
    parameter  int WAYS   = 4,
    parameter  int SETS   = 4,
    parameter  int WORDS  = 4,
    parameter  int ADDR_W = 30,
    localparam int OFF_W  = log2c(WORDS),
    localparam int BLK_W  = WORD_W * WORDS
) (
    input  logic                    clk,
    input  logic                    proc_reset_n,
    input  logic                    proc_read,
    input  logic                    proc_write,
    input  logic [ADDR_W-1:0]       proc_addr,
    input  logic [31:0]             proc_wdata,
    output logic [31:0]             proc_rdata,
    output logic                    proc_stall,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-OFF_W-1:0] mem_addr,
    output logic [BLK_W-1:0]        mem_wdata,
    input  logic [BLK_W-1:0]        mem_rdata,
    input  logic                    mem_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]             perf_hit,
    output logic [31:0]             perf_miss,
    output logic [31:0]             perf_wb
`endif
);

    localparam int IDX_W = log2c(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = age_w(WAYS);

    // state | meaning: IDLE serve hits | WRITEBACK flush dirty victim | READMISS refill
    state_t           state;
    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic [BLK_W-1:0] data_mem  [SETS][WAYS];
    logic [WAYS-1:0]  valid_mem [SETS];
    logic [WAYS-1:0]  dirty_mem [SETS];
    logic [WAY_W-1:0] victim_q, lru_victim, vic_way, hit_way, lru_way;
    logic             mem_ready_q;
    logic [BLK_W-1:0] mem_rdata_q, fill_blk;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic [WAYS-1:0]  hit_vec;
    logic             req, hit, acc_hit, miss, fill, vic_dirty, lru_upd;
`ifdef CACHE_PERF_CNT_EN
    logic             fill_done_q;
`endif

    assign req_tag = proc_addr[ADDR_W-1 -: TAG_W];
    assign idx     = proc_addr[OFF_W +: IDX_W];
    assign off     = proc_addr[OFF_W-1:0];
    assign req     = proc_read | proc_write;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_mem[idx][w] && (tag_mem[idx][w] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit       = |hit_vec;
    assign acc_hit   = proc_reset_n && (state == ST_IDLE) && req && hit;
    assign miss      = proc_reset_n && (state == ST_IDLE) && req && !hit;
    assign fill      = proc_reset_n && (state == ST_READMISS) && mem_ready_q;
    assign vic_way   = (state == ST_IDLE) ? lru_victim : victim_q;
    assign vic_dirty = valid_mem[idx][vic_way] && dirty_mem[idx][vic_way];
    assign lru_upd   = acc_hit || fill;
    assign lru_way   = fill ? victim_q : hit_way;

    cache_lru_age #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clk         (clk),
        .proc_reset_n(proc_reset_n),
        .index       (idx),
        .valid       (valid_mem[idx]),
        .access_way  (lru_way),
        .update      (lru_upd),
        .victim      (lru_victim)
    );

    always_comb begin
        fill_blk = mem_rdata_q;
        if (proc_write) fill_blk[{off, 5'd0} +: 32] = proc_wdata;
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[idx][victim_q] <= fill_blk;
            tag_mem[idx][victim_q]  <= req_tag;
        end else if (acc_hit && proc_write) begin
            data_mem[idx][hit_way][{off, 5'd0} +: 32] <= proc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state       <= ST_IDLE;
            victim_q    <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
            end
`ifdef CACHE_PERF_CNT_EN
            fill_done_q <= 1'b0;
            perf_hit    <= '0;
            perf_miss   <= '0;
            perf_wb     <= '0;
`endif
        end else begin
            mem_ready_q <= mem_ready;
            mem_rdata_q <= mem_rdata;
            case (state)
                ST_IDLE: begin
                    if (acc_hit && proc_write) begin
                        dirty_mem[idx][hit_way] <= 1'b1;
                    end else if (miss) begin
                        victim_q <= lru_victim;
                        state    <= vic_dirty ? ST_WRITEBACK : ST_READMISS;
                    end
                end
                ST_WRITEBACK: if (mem_ready_q) state <= ST_READMISS;
                ST_READMISS: begin
                    if (mem_ready_q) begin
                        valid_mem[idx][victim_q] <= 1'b1;
                        dirty_mem[idx][victim_q] <= proc_write;
                        state                    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef CACHE_PERF_CNT_EN
            // The replayed access right after a refill is not a fresh hit.
            fill_done_q <= fill;
            if (acc_hit && !fill_done_q && perf_hit != '1) perf_hit <= perf_hit + 1'b1;
            if (miss && perf_miss != '1) perf_miss <= perf_miss + 1'b1;
            if (state == ST_WRITEBACK && mem_ready_q && perf_wb != '1) perf_wb <= perf_wb + 1'b1;
`endif
        end
    end

    always_comb begin
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        if (proc_reset_n) begin
            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        proc_stall = 1'b1;
                        mem_write  = vic_dirty;
                        mem_read   = !vic_dirty;
                    end
                end
                ST_WRITEBACK: begin
                    proc_stall = 1'b1;
                    mem_read   = mem_ready_q;
                    mem_write  = !mem_ready_q;
                end
                ST_READMISS: begin
                    proc_stall = 1'b1;
                    mem_read   = 1'b1;
                end
                default: ;
            endcase
        end
        mem_addr   = mem_write ? {tag_mem[idx][vic_way], idx} : {req_tag, idx};
        mem_wdata  = mem_write ? data_mem[idx][vic_way] : '0;
        proc_rdata = acc_hit ? data_mem[idx][hit_way][{off, 5'd0} +: 32] : '0;
    end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway (4 ways, 4 sets, 4 words) with a memory
// responder and scoreboard queues; perf counters checked under CACHE_PERF_CNT_EN.
module tb_cache_nway;

    logic         clk = 1'b0;
    logic         proc_reset_n = 1'b0;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]  perf_hit, perf_miss, perf_wb;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_op_t;

    mem_op_t      exp_mem[$];
    logic [31:0]  rd_q[$];
    logic [31:0]  ref_w[logic [29:0]];
    logic [127:0] mem_store[logic [27:0]];

    always #5 clk = ~clk;

    cache_nway #(.WAYS(4), .SETS(4), .WORDS(4), .ADDR_W(30)) dut (
        .clk         (clk),
        .proc_reset_n(proc_reset_n),
        .proc_read   (proc_read),
        .proc_write  (proc_write),
        .proc_addr   (proc_addr),
        .proc_wdata  (proc_wdata),
        .proc_rdata  (proc_rdata),
        .proc_stall  (proc_stall),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
`ifdef CACHE_PERF_CNT_EN
        ,
        .perf_hit    (perf_hit),
        .perf_miss   (perf_miss),
        .perf_wb     (perf_wb)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [29:0] a);
        return (a == 30'h011) ? 32'hAAAA0001 : {2'b11, a};
    endfunction

    function automatic logic [127:0] pat_blk(input logic [27:0] b);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = pat({b, 2'(i)});
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] a);
        return ref_w.exists(a) ? ref_w[a] : pat(a);
    endfunction

    function automatic logic [127:0] ref_blk(input logic [27:0] b);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = ref_rd({b, 2'(i)});
        return r;
    endfunction

    task automatic exp_rd(input logic [27:0] b);
        mem_op_t o;
        o.wr = 1'b0; o.addr = b; o.data = '0;
        exp_mem.push_back(o);
    endtask

    task automatic exp_wb(input logic [27:0] b);
        mem_op_t o;
        o.wr = 1'b1; o.addr = b; o.data = ref_blk(b);
        exp_mem.push_back(o);
    endtask

    // Memory responder: accepts a request, answers with a one-cycle mem_ready
    // two cycles later, then ignores the cycle in which the pulse drains.
    int      mphase = 0;
    int      mcnt = 0;
    logic [127:0] rd_blk = '0;
    always @(negedge clk) begin
        mem_op_t op;
        if (mem_read | mem_write) chk("rd_wr_exclusive", {127'b0, mem_read & mem_write}, 128'd0);
        if (mphase == 2) begin
            mem_ready = 1'b0;
            mphase = 0;
        end else if (mphase == 1) begin
            mcnt--;
            if (mcnt == 0) begin
                mem_rdata = rd_blk;
                mem_ready = 1'b1;
                mphase = 2;
            end
        end else if (mem_read | mem_write) begin
            checks++;
            assert (exp_mem.size() != 0) else begin
                failures++;
                $error("FAIL mem_unexpected observed wr=%0b addr=%0h expected no request", mem_write, mem_addr);
            end
            if (exp_mem.size() != 0) begin
                op = exp_mem.pop_front();
                chk("mem_op_write", {127'b0, mem_write}, {127'b0, op.wr});
                chk("mem_addr", {100'b0, mem_addr}, {100'b0, op.addr});
                if (op.wr) chk("mem_wdata", mem_wdata, op.data);
            end
            if (mem_write) mem_store[mem_addr] = mem_wdata;
            else rd_blk = mem_store.exists(mem_addr) ? mem_store[mem_addr] : pat_blk(mem_addr);
            mphase = 1;
            mcnt = 2;
        end
    end

    task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] wd, input bit exp_hit);
        int n;
        logic [31:0] e;
        @(posedge clk); #1;
        proc_addr = a; proc_wdata = wd; proc_write = wr; proc_read = !wr;
        if (!wr) rd_q.push_back(ref_rd(a));
        else ref_w[a] = wd;
        @(negedge clk);
        chk("first_cycle_stall", {127'b0, proc_stall}, {127'b0, !exp_hit});
        if (exp_hit) begin
            chk("hit_no_mem_read", {127'b0, mem_read}, 128'd0);
            chk("hit_no_mem_write", {127'b0, mem_write}, 128'd0);
            chk("hit_mem_addr", {100'b0, mem_addr}, {100'b0, a[29:2]});
        end
        n = 0;
        while (proc_stall === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_bound", {127'b0, n < 100}, 128'd1);
        if (!wr) begin
            e = rd_q.pop_front();
            chk("proc_rdata", {96'b0, proc_rdata}, {96'b0, e});
        end
        @(posedge clk); #1;
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    task automatic check_perf(input logic [31:0] h, input logic [31:0] m, input logic [31:0] w);
`ifdef CACHE_PERF_CNT_EN
        @(negedge clk);
        chk("perf_hit", {96'b0, perf_hit}, {96'b0, h});
        chk("perf_miss", {96'b0, perf_miss}, {96'b0, m});
        chk("perf_wb", {96'b0, perf_wb}, {96'b0, w});
`endif
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        proc_reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 proc_reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a request pending: everything quiet.
        proc_read = 1'b1; proc_addr = 30'h010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {127'b0, proc_stall}, 128'd0);
        chk("rst_mem_read", {127'b0, mem_read}, 128'd0);
        chk("rst_mem_write", {127'b0, mem_write}, 128'd0);
        chk("rst_rdata", {96'b0, proc_rdata}, 128'd0);
        chk("rst_wdata", mem_wdata, 128'd0);
        @(posedge clk); #1;
        proc_read = 1'b0; proc_reset_n = 1'b1;
        check_perf(0, 0, 0);

        // Fill set 0 with four tags, touch the first, then a fifth evicts 0x020's line.
        exp_rd(28'h004); access(0, 30'h010, 0, 0);
        exp_rd(28'h008); access(0, 30'h020, 0, 0);
        exp_rd(28'h00C); access(0, 30'h030, 0, 0);
        exp_rd(28'h010); access(0, 30'h040, 0, 0);
        access(0, 30'h010, 0, 1);
        exp_rd(28'h014); access(0, 30'h050, 0, 0);
        check_perf(1, 5, 0);
        exp_rd(28'h008); access(0, 30'h020, 0, 0);

        // Cold read after reset, then two hits on the refilled block.
        pulse_reset();
        check_perf(0, 0, 0);
        exp_rd(28'h004); access(0, 30'h010, 0, 0);
        access(0, 30'h011, 0, 1);
        access(0, 30'h011, 0, 1);

        // Dirty line eviction writes back before refilling.
        exp_rd(28'h008); access(0, 30'h020, 0, 0);
        access(1, 30'h021, 32'hDEADBEEF, 1);
        access(0, 30'h021, 0, 1);
        exp_rd(28'h00C); access(0, 30'h030, 0, 0);
        exp_rd(28'h010); access(0, 30'h040, 0, 0);
        access(0, 30'h010, 0, 1);
        exp_wb(28'h008); exp_rd(28'h014); access(0, 30'h050, 0, 0);
`ifdef CACHE_PERF_CNT_EN
        @(negedge clk);
        chk("perf_wb_after_evict", {96'b0, perf_wb}, 128'd1);
`endif

        // Write miss merges into the refill; the word survives to writeback.
        exp_rd(28'h018); access(0, 30'h060, 0, 0);
        exp_rd(28'h00C); access(1, 30'h032, 32'h12345678, 0);
        access(0, 30'h032, 0, 1);
        access(0, 30'h010, 0, 1);
        access(0, 30'h050, 0, 1);
        access(0, 30'h060, 0, 1);
        exp_wb(28'h00C); exp_rd(28'h01C); access(0, 30'h070, 0, 0);
        exp_rd(28'h008); access(0, 30'h021, 0, 0);

        // Reset in the middle of a refill aborts it.
        exp_rd(28'h024);
        @(posedge clk); #1;
        proc_addr = 30'h090; proc_read = 1'b1;
        @(negedge clk);
        chk("abort_miss_stall", {127'b0, proc_stall}, 128'd1);
        @(negedge clk);
        chk("abort_readmiss_rd", {127'b0, mem_read}, 128'd1);
        @(posedge clk); #1;
        proc_reset_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_rd", {127'b0, mem_read}, 128'd0);
        chk("abort_rst_stall", {127'b0, proc_stall}, 128'd0);
        @(negedge clk);
        chk("abort_rst_rd_hold", {127'b0, mem_read}, 128'd0);
        chk("abort_rst_rdata", {96'b0, proc_rdata}, 128'd0);
        repeat (3) @(posedge clk);
        #1 proc_reset_n = 1'b1; proc_read = 1'b0;
        exp_rd(28'h008); access(0, 30'h021, 0, 0);
        exp_rd(28'h024); access(0, 30'h090, 0, 0);

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("mem_queue_drained", 128'(exp_mem.size()), 128'd0);
        chk("rd_queue_drained", 128'(rd_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
